reset_sequencer: RTL

Staged reset-release controller for multi-domain designs. It holds every downstream reset domain in reset after power-up or a board reset, then releases the domains one at a time, in index order, at a fixed prescaled interval. A requester can later re-arm the whole sequence through a request/acknowledge handshake. It sits between the top-level reset source and the per-subsystem reset inputs, for example dividers and peripheral cores.

---
 rtl/reset_sequencer_if.sv | 34 +++
 rtl/reset_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// ============================================================================
// Module   : reset_sequencer_if
// Purpose  : Restart handshake and per-domain reset outputs of reset_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   restart_req;
  logic                   restart_ack;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   all_released;
  logic                   busy;

  modport master (
    input  restart_req,
    output restart_ack,
    output domain_reset,
    output all_released,
    output busy
  );

  modport slave (
    output restart_req,
    input  restart_ack,
    input  domain_reset,
    input  all_released,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Staged reset release across NUM_DOMAINS domains, with a
//            request/ack re-arm. Option macro: RESET_SEQUENCER_ORDERED_ASSERT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int PRESCALE    = 16,
  parameter int STEP_TICKS  = 8
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  reset_sequencer_if.master  bus
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int ST_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STEP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
  typedef enum logic [1:0] {ST_WAIT, ST_DONE, ST_ASSERT} state_t;
`else
  typedef enum logic [1:0] {ST_WAIT, ST_DONE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [PS_W-1:0]        ps_q, ps_d;
  logic [ST_W-1:0]        st_q, st_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dr_q, dr_d;
  logic                   ack_q, ack_d;
  logic                   tick;

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
  logic [NUM_DOMAINS-1:0] spread;
  // Each tick extends the asserted run one bit further down the index order.
  assign spread = dr_q | (dr_q >> 1);
`endif

  assign tick = (ps_q == PS_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      ps_q    <= '0;
      st_q    <= '0;
      idx_q   <= '0;
      dr_q    <= '1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      st_q    <= st_d;
      idx_q   <= idx_d;
      dr_q    <= dr_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    st_d    = st_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_WAIT: begin
        ps_d = tick ? '0 : ps_q + 1'b1;
        if (tick) begin
          if (st_q == ST_LAST) begin
            st_d  = '0;
            idx_d = idx_q + 1'b1;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IDX_W'(i)) dr_d[i] = 1'b0;
            end
            if (idx_q == IDX_LAST) state_d = ST_DONE;
          end else begin
            st_d = st_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (bus.restart_req) begin
          ack_d = 1'b1;
          ps_d  = '0;
          st_d  = '0;
          idx_d = '0;
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
          dr_d                = '0;
          dr_d[NUM_DOMAINS-1] = 1'b1;
          state_d             = (NUM_DOMAINS == 1) ? ST_WAIT : ST_ASSERT;
`else
          dr_d    = '1;
          state_d = ST_WAIT;
`endif
        end
      end

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
      ST_ASSERT: begin
        ps_d = tick ? '0 : ps_q + 1'b1;
        if (tick) begin
          dr_d = spread;
          if (spread[0]) begin
            state_d = ST_WAIT;
            st_d    = '0;
            idx_d   = '0;
          end
        end
      end
`endif

      default: state_d = ST_WAIT;
    endcase
  end

  assign bus.restart_ack  = ack_q;
  assign bus.domain_reset = dr_q;
  assign bus.all_released = ~|dr_q;
  assign bus.busy         = (state_q != ST_DONE);

endmodule

`default_nettype wire
